// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one variable-latency memory between the fetch and data ports.
// Data port has priority; a burst counter bounds how long a pending fetch can wait.
module mem_port_arbiter #(
    parameter int WORD     = 32,
    parameter int DM_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [WORD-1:0] if_addr,
    output logic [WORD-1:0] if_rdata,
    output logic            if_ready,
    input  logic            dm_read,
    input  logic            dm_write,
    input  logic [WORD-1:0] dm_addr,
    input  logic [WORD-1:0] dm_wdata,
    output logic [WORD-1:0] dm_rdata,
    output logic            dm_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [WORD-1:0] mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            stall_if,
    output logic            stall_mem
);

    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_DM} state_t;

    localparam int CW = $clog2(DM_BURST + 1);

    state_t        state;
    logic [CW-1:0] burst_cnt;
    logic          dm_any;
    logic          dm_win;
    logic          room;

    assign dm_any    = dm_read | dm_write;
    assign room      = burst_cnt < CW'(DM_BURST);
    assign dm_win    = dm_any & (~if_req | room);
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_any & ~dm_ready;

    // A port whose ready is pulsing is masked; if it would otherwise win,
    // nobody is granted this cycle so priority is not handed to the loser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            burst_cnt <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (dm_win) begin
                        if (!dm_ready) begin
                            state     <= GNT_DM;
                            mem_req   <= 1'b1;
                            mem_we    <= dm_write;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (if_req && room)
                                burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (if_req) begin
                        if (!if_ready) begin
                            state     <= GNT_IF;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            burst_cnt <= '0;
                        end
                    end
                    if (!if_req)
                        burst_cnt <= '0;
                end
                GNT_IF: begin
                    if (mem_ack) begin
                        if_rdata <= mem_rdata;
                        if_ready <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                GNT_DM: begin
                    if (mem_ack) begin
                        if (!mem_we)
                            dm_rdata <= mem_rdata;
                        dm_ready <= 1'b1;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction-level
// reference model compared every cycle, and literal spot checks.
module tb_mem_port_arbiter;

    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;

    mem_port_arbiter #(.WORD(32), .DM_BURST(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_read(dm_read), .dm_write(dm_write),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // memory: acks after wt wait cycles of mem_req; force_ack pulses it freely
    int          wt = 0;
    int          mcnt = 0;
    bit          force_ack = 0;
    logic [31:0] rd_val = '0;

    always @(negedge clk) begin
        if (mem_req) begin
            mem_ack = (mcnt == wt) || force_ack;
            mcnt++;
        end else begin
            mcnt = 0;
            mem_ack = force_ack;
        end
        mem_rdata = rd_val;
    end

    // reference model: which port owns the memory and what it latched
    int          owner = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_ird = '0;
    logic [31:0] m_drd = '0;
    logic        m_ir = 0;
    logic        m_dr = 0;
    int          streak = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_ird = '0; m_drd = '0; m_ir = 0; m_dr = 0; streak = 0;
        end else begin
            automatic bit was_ir = m_ir;
            automatic bit was_dr = m_dr;
            automatic bit dm_want = dm_read | dm_write;
            automatic bit fetch_ok_wait = !if_req || streak < BURST;
            m_ir = 0;
            m_dr = 0;
            if (owner != 0) begin
                if (mem_ack) begin
                    if (owner == 1) begin
                        m_ird = mem_rdata; m_ir = 1;
                    end else begin
                        if (!m_we) m_drd = mem_rdata;
                        m_dr = 1;
                    end
                    owner = 0;
                    m_we = 0;
                end
            end else begin
                if (dm_want && fetch_ok_wait) begin
                    if (!was_dr) begin
                        owner = 2;
                        m_we = dm_write;
                        m_addr = dm_addr;
                        m_wdata = dm_wdata;
                        if (if_req) streak = streak + 1;
                    end
                end else if (if_req && !was_ir) begin
                    owner = 1;
                    m_we = 0;
                    m_addr = if_addr;
                    m_wdata = '0;
                    streak = 0;
                end
                if (!if_req) streak = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("mem_req", mem_req, owner != 0);
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("if_ready", if_ready, m_ir);
        chk("dm_ready", dm_ready, m_dr);
        chk("if_rdata", if_rdata, m_ird);
        chk("dm_rdata", dm_rdata, m_drd);
        chk("stall_if", stall_if, if_req & ~m_ir);
        chk("stall_mem", stall_mem, (dm_read | dm_write) & ~m_dr);
    end

    // grant log: address of every new memory transaction
    logic [31:0] glog[$];
    logic        prev_req = 0;

    always @(negedge clk) begin
        if (mem_req && !prev_req) glog.push_back(mem_addr);
        prev_req = mem_req;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input bit dm, input int max,
                              output int reqc, output int n, output bit we_seen);
        bit got = 0;
        reqc = 0; n = 0; we_seen = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            n++;
            if (mem_req) reqc++;
            if (mem_req && mem_we) we_seen = 1;
            if (dm ? dm_ready : if_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) timeout(dm ? "dm_ready_wait" : "if_ready_wait");
        #1;
    endtask

    initial begin
        int  rc, nn;
        bit  we;
        logic [31:0] exp_burst [6];
        exp_burst = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h80, 32'h300};

        cyc(2);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_rdata", dm_rdata, 0);
        rst_n = 1;
        cyc(2);

        // single fetch, zero-wait memory
        rd_val = 32'h8C08_0004; wt = 0;
        if_addr = 32'h40; if_req = 1;
        wait_ready(0, 20, rc, nn, we);
        if_req = 0;
        chk("t1_req_cycles", rc, 1);
        chk("t1_latency", nn, 2);
        chk("t1_we", we, 0);
        chk("t1_if_rdata", if_rdata, 32'h8C08_0004);
        chk("t1_addr", glog[0], 32'h40);
        cyc(2);

        // simultaneous fetch and load: load wins
        glog.delete();
        rd_val = 32'h1111_2222;
        if_addr = 32'h44; if_req = 1;
        dm_addr = 32'h100; dm_read = 1;
        wait_ready(1, 20, rc, nn, we);
        dm_read = 0;
        chk("t2_if_pending", if_ready, 0);
        wait_ready(0, 20, rc, nn, we);
        if_req = 0;
        chk("t2_ngrants", glog.size(), 2);
        chk("t2_first", glog[0], 32'h100);
        chk("t2_second", glog[1], 32'h44);
        cyc(2);

        // store with 5 wait states
        glog.delete();
        rd_val = 32'h9999_0000; wt = 5;
        dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_write = 1;
        wait_ready(1, 30, rc, nn, we);
        dm_write = 0;
        chk("t3_req_cycles", rc, 6);
        chk("t3_we", we, 1);
        chk("t3_dm_rdata", dm_rdata, 32'h1111_2222);
        chk("t3_addr", glog[0], 32'h200);
        cyc(2);

        // bounded burst: four loads, one fetch, loads resume
        glog.delete();
        rd_val = 32'h0000_0013; wt = 0;
        dm_addr = 32'h300; dm_read = 1;
        if_addr = 32'h80; if_req = 1;
        for (int i = 0; i < 200 && glog.size() < 6; i++) cyc(1);
        if (glog.size() < 6) timeout("t4_grants");
        dm_read = 0; if_req = 0;
        cyc(12);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t4_grant%0d", i),
                i < glog.size() ? glog[i] : 32'hX, exp_burst[i]);

        // reset in the middle of a 5-cycle load
        glog.delete();
        rd_val = 32'h5555_AAAA; wt = 4;
        dm_addr = 32'h400; dm_read = 1;
        for (int i = 0; i < 20 && mcnt < 2; i++) @(negedge clk);
        #1 rst_n = 0;
        #1 chk("t5_async_drop", mem_req, 0);
        chk("t5_no_ready", dm_ready, 0);
        @(negedge clk);
        chk("t5_rdata_reset", dm_rdata, 0);
        #1 rst_n = 1;
        wait_ready(1, 30, rc, nn, we);
        dm_read = 0;
        chk("t5_regrant", glog.size(), 2);
        chk("t5_dm_rdata", dm_rdata, 32'h5555_AAAA);
        cyc(2);

        // ack while idle is ignored
        rd_val = 32'hFFFF_0000;
        force_ack = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("t6_if_ready", if_ready, 0);
            chk("t6_dm_ready", dm_ready, 0);
        end
        force_ack = 0;
        cyc(2);
        chk("t6_mem_req", mem_req, 0);
        chk("t6_if_rdata", if_rdata, 0);
        chk("t6_dm_rdata", dm_rdata, 32'h5555_AAAA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
